// File: rtl/pcb_read_arbiter.sv
// Shares the PCB read port among NUM_REQ read controllers (round-robin) and routes returned data
// back through an in-order tag FIFO. Optional build macro: PCB_RD_ARB_HOST_PRIO_EN (host wins outright).
module pcb_read_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int TAG_DEPTH = 4,
    parameter int DATA_W    = 134
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ*16-1:0] iv_req_raddr,
    input  logic [NUM_REQ-1:0]    iv_req_rd,
    output logic [NUM_REQ-1:0]    ov_req_ack,
    output logic [15:0]           ov_pcb_raddr,
    output logic                  o_pcb_rd,
    input  logic                  i_pcb_raddr_ack,
    input  logic [DATA_W-1:0]     iv_pcb_rdata,
    input  logic                  i_pcb_rdata_valid,
    output logic [DATA_W-1:0]     ov_rdata,
    output logic [NUM_REQ-1:0]    ov_rdata_valid,
    output logic                  o_tag_err,
    output logic [15:0]           ov_grant_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef PCB_RD_ARB_HOST_PRIO_EN
    localparam bit HOST_PRIO = 1'b1;
`else
    localparam bit HOST_PRIO = 1'b0;
`endif

    typedef enum logic {
        ARB_IDLE = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    state_t             state;
    state_t             state_nxt;
    idx_t               rr_ptr;
    idx_t               grant_idx;
    idx_t               win_idx;
    logic               win_found;
    logic [15:0]        win_addr;
    logic [NUM_REQ-1:0] rr_req;
    logic               host_win;
    logic               host_grant;
    logic               grant_fire;
    logic               ack_fire;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   tag_cnt;
    logic               tag_full;
    logic               tag_empty;
    idx_t               tag_mem [TAG_DEPTH];

    function automatic logic [NUM_REQ-1:0] onehot(input idx_t idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (idx == idx_t'(i));
        end
        return v;
    endfunction

    function automatic idx_t next_idx(input idx_t idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // With host priority the host is taken out of the round-robin pass and never moves rr_ptr.
    assign host_win   = HOST_PRIO && iv_req_rd[NUM_REQ-1];
    assign rr_req     = HOST_PRIO ? (iv_req_rd & ~onehot(idx_t'(NUM_REQ - 1))) : iv_req_rd;
    assign host_grant = HOST_PRIO && (int'(grant_idx) == NUM_REQ - 1);

    assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);

    // Winner search: first asserted requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IDX_W:0] pos;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        if (host_win) begin
            win_found = 1'b1;
            win_idx   = idx_t'(NUM_REQ - 1);
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pos = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
                if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                    pos = pos - (IDX_W + 1)'(NUM_REQ);
                end
                if (!win_found && rr_req[pos[IDX_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = pos[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == idx_t'(i)) begin
                win_addr = iv_req_raddr[16*i +: 16];
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE: if (grant_fire)      state_nxt = WAIT_ACK;
            WAIT_ACK: if (i_pcb_raddr_ack) state_nxt = ARB_IDLE;
            default:                       state_nxt = ARB_IDLE;
        endcase
    end

    // Output decode; the full check uses the registered count, so a same-cycle pop cannot unblock a grant.
    always_comb begin
        grant_fire = (state == ARB_IDLE) && win_found && !tag_full;
        ack_fire   = (state == WAIT_ACK) && i_pcb_raddr_ack;
        push       = ack_fire;
        pop        = i_pcb_rdata_valid && !tag_empty;
    end

    // Request side: address/strobe to the PCB, ack back to the requester, round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pcb_rd     <= 1'b0;
            ov_pcb_raddr <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            ov_req_ack   <= '0;
            ov_grant_cnt <= '0;
        end else begin
            ov_req_ack <= '0;
            if (state == ARB_IDLE) begin
                o_pcb_rd <= grant_fire;
                if (grant_fire) begin
                    ov_pcb_raddr <= win_addr;
                    grant_idx    <= win_idx;
                end else begin
                    ov_pcb_raddr <= '0;
                end
            end else if (ack_fire) begin
                o_pcb_rd     <= 1'b0;
                ov_req_ack   <= onehot(grant_idx);
                ov_grant_cnt <= ov_grant_cnt + 16'd1;
                if (!host_grant) begin
                    rr_ptr <= next_idx(grant_idx);
                end
            end
        end
    end

    // NOTE: tag storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    // Pointers wrap naturally because TAG_DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Return side: registered data plus one-hot valid to the oldest outstanding requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_rdata       <= '0;
            ov_rdata_valid <= '0;
            o_tag_err      <= 1'b0;
        end else begin
            ov_rdata_valid <= '0;
            if (pop) begin
                ov_rdata       <= iv_pcb_rdata;
                ov_rdata_valid <= onehot(tag_mem[rd_ptr]);
            end
            if (i_pcb_rdata_valid && tag_empty) begin
                o_tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcb_read_arbiter.sv
// Directed, table-driven bench for pcb_read_arbiter: one record per clock cycle of inputs and
// expected registered outputs, plus hand sequences for reset-in-flight and host arbitration.
module tb_pcb_read_arbiter;

    localparam int NUM_REQ   = 5;
    localparam int TAG_DEPTH = 4;
    localparam int DATA_W    = 134;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n;
    logic [NUM_REQ*16-1:0] iv_req_raddr;
    logic [NUM_REQ-1:0]    iv_req_rd;
    logic [NUM_REQ-1:0]    ov_req_ack;
    logic [15:0]           ov_pcb_raddr;
    logic                  o_pcb_rd;
    logic                  i_pcb_raddr_ack;
    logic [DATA_W-1:0]     iv_pcb_rdata;
    logic                  i_pcb_rdata_valid;
    logic [DATA_W-1:0]     ov_rdata;
    logic [NUM_REQ-1:0]    ov_rdata_valid;
    logic                  o_tag_err;
    logic [15:0]           ov_grant_cnt;

    pcb_read_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TAG_DEPTH(TAG_DEPTH),
        .DATA_W   (DATA_W)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .iv_req_raddr     (iv_req_raddr),
        .iv_req_rd        (iv_req_rd),
        .ov_req_ack       (ov_req_ack),
        .ov_pcb_raddr     (ov_pcb_raddr),
        .o_pcb_rd         (o_pcb_rd),
        .i_pcb_raddr_ack  (i_pcb_raddr_ack),
        .iv_pcb_rdata     (iv_pcb_rdata),
        .i_pcb_rdata_valid(i_pcb_rdata_valid),
        .ov_rdata         (ov_rdata),
        .ov_rdata_valid   (ov_rdata_valid),
        .o_tag_err        (o_tag_err),
        .ov_grant_cnt     (ov_grant_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  req;
        logic        ack;
        logic        rv;
        logic [15:0] data;
        logic        exp_rd;
        logic [15:0] exp_addr;
        logic [4:0]  exp_ack;
        logic [4:0]  exp_vld;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [28];
    int   exp_g [4];

    function automatic logic [15:0] addr_of(input int r);
        return 16'(16'h0080 * (r + 1));
    endfunction

    function automatic logic [DATA_W-1:0] widen(input logic [15:0] d);
        return {6'h2A, {8{d}}};
    endfunction

    function automatic int oh(input int g);
        return 1 << g;
    endfunction

    function automatic vec_t mk(input int req, input int ack, input int rv, input int data,
                                input int erd, input int eaddr, input int eack, input int evld,
                                input int edata, input int eerr, input int ecnt);
        vec_t v;
        v.req      = 5'(req);
        v.ack      = (ack != 0);
        v.rv       = (rv != 0);
        v.data     = 16'(data);
        v.exp_rd   = (erd != 0);
        v.exp_addr = 16'(eaddr);
        v.exp_ack  = 5'(eack);
        v.exp_vld  = 5'(evld);
        v.exp_data = 16'(edata);
        v.exp_err  = (eerr != 0);
        v.exp_cnt  = 16'(ecnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare registered outputs just after the edge.
    task automatic apply(input vec_t v, input string tag);
        iv_req_rd         = v.req;
        i_pcb_raddr_ack   = v.ack;
        i_pcb_rdata_valid = v.rv;
        iv_pcb_rdata      = widen(v.data);
        @(posedge i_clk);
        #1;
        check({tag, ".pcb_rd"}, o_pcb_rd, v.exp_rd);
        if (v.exp_rd) check({tag, ".raddr"}, ov_pcb_raddr, v.exp_addr);
        check({tag, ".req_ack"}, ov_req_ack, v.exp_ack);
        check({tag, ".rdata_valid"}, ov_rdata_valid, v.exp_vld);
        if (v.exp_vld != '0) check({tag, ".rdata"}, ov_rdata, widen(v.exp_data));
        check({tag, ".tag_err"}, o_tag_err, v.exp_err);
        check({tag, ".grant_cnt"}, ov_grant_cnt, v.exp_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pcb_rd"}, o_pcb_rd, 1'b0);
        check({tag, ".raddr"}, ov_pcb_raddr, 16'h0);
        check({tag, ".req_ack"}, ov_req_ack, 5'b0);
        check({tag, ".rdata_valid"}, ov_rdata_valid, 5'b0);
        check({tag, ".rdata"}, ov_rdata, '0);
        check({tag, ".tag_err"}, o_tag_err, 1'b0);
        check({tag, ".grant_cnt"}, ov_grant_cnt, 16'h0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < NUM_REQ; r++) iv_req_raddr[16*r +: 16] = addr_of(r);
        iv_req_rd         = '0;
        i_pcb_raddr_ack   = 1'b0;
        i_pcb_rdata_valid = 1'b0;
        iv_pcb_rdata      = '0;
        i_rst_n           = 1'b0;

        // Round-robin over 0,1,3 with immediate acks; one overlapping push/pop, then a full stall.
        vecs[0]  = mk('b01011, 0, 0, 0,      1, 'h0080, 0,       0,       0,      0, 0);
        vecs[1]  = mk('b01011, 1, 0, 0,      0, 0,      'b00001, 0,       0,      0, 1);
        vecs[2]  = mk('b01011, 0, 0, 0,      1, 'h0100, 0,       0,       0,      0, 1);
        vecs[3]  = mk('b01011, 1, 0, 0,      0, 0,      'b00010, 0,       0,      0, 2);
        vecs[4]  = mk('b01011, 0, 0, 0,      1, 'h0200, 0,       0,       0,      0, 2);
        vecs[5]  = mk('b01011, 1, 1, 'h00B0, 0, 0,      'b01000, 'b00001, 'h00B0, 0, 3);
        vecs[6]  = mk('b01011, 0, 0, 0,      1, 'h0080, 0,       0,       0,      0, 3);
        vecs[7]  = mk('b01011, 1, 0, 0,      0, 0,      'b00001, 0,       0,      0, 4);
        vecs[8]  = mk('b01011, 0, 0, 0,      1, 'h0100, 0,       0,       0,      0, 4);
        vecs[9]  = mk('b01011, 1, 0, 0,      0, 0,      'b00010, 0,       0,      0, 5);
        vecs[10] = mk('b01011, 0, 1, 'h00B1, 0, 0,      0,       'b00010, 'h00B1, 0, 5);
        vecs[11] = mk('b01011, 0, 0, 0,      1, 'h0200, 0,       0,       0,      0, 5);
        vecs[12] = mk('b01011, 1, 0, 0,      0, 0,      'b01000, 0,       0,      0, 6);
        vecs[13] = mk(0,       0, 1, 'h00B2, 0, 0,      0,       'b01000, 'h00B2, 0, 6);
        vecs[14] = mk(0,       0, 1, 'h00B3, 0, 0,      0,       'b00001, 'h00B3, 0, 6);
        vecs[15] = mk(0,       0, 1, 'h00B4, 0, 0,      0,       'b00010, 'h00B4, 0, 6);
        vecs[16] = mk(0,       0, 1, 'h00B5, 0, 0,      0,       'b01000, 'h00B5, 0, 6);
        vecs[17] = mk(0,       0, 0, 0,      0, 0,      0,       0,       0,      0, 6);
        // Single request from requester 2, ack three cycles into the strobe, data two cycles later.
        vecs[18] = mk('b00100, 0, 0, 0,      1, 'h0180, 0,       0,       0,      0, 6);
        vecs[19] = mk('b00100, 0, 0, 0,      1, 'h0180, 0,       0,       0,      0, 6);
        vecs[20] = mk('b00100, 0, 0, 0,      1, 'h0180, 0,       0,       0,      0, 6);
        vecs[21] = mk('b00100, 0, 0, 0,      1, 'h0180, 0,       0,       0,      0, 6);
        vecs[22] = mk('b00100, 1, 0, 0,      0, 0,      'b00100, 0,       0,      0, 7);
        vecs[23] = mk(0,       0, 0, 0,      0, 0,      0,       0,       0,      0, 7);
        vecs[24] = mk(0,       0, 1, 'h00A1, 0, 0,      0,       'b00100, 'h00A1, 0, 7);
        vecs[25] = mk(0,       0, 0, 0,      0, 0,      0,       0,       0,      0, 7);
        // Data with nothing outstanding: no valid, sticky error.
        vecs[26] = mk(0,       0, 1, 'h00EE, 0, 0,      0,       0,       0,      1, 7);
        vecs[27] = mk(0,       0, 0, 0,      0, 0,      0,       0,       0,      1, 7);

`ifdef PCB_RD_ARB_HOST_PRIO_EN
        exp_g = '{4, 4, 4, 4};
`else
        exp_g = '{0, 4, 0, 4};
`endif

        #12;
        check_all_zero("reset");
        i_rst_n = 1'b1;

        for (int i = 0; i < 28; i++) apply(vecs[i], $sformatf("v%0d", i));

        // Reset while a grant waits for its ack, with one older tag still outstanding.
        apply(mk('b00100, 0, 0, 0,      1, 'h0180, 0,       0,       0,      1, 7), "rst0");
        apply(mk('b00100, 1, 0, 0,      0, 0,      'b00100, 0,       0,      1, 8), "rst1");
        apply(mk('b01010, 0, 0, 0,      1, 'h0200, 0,       0,       0,      1, 8), "rst2");
        pulse_reset("rst_wait_ack");
        apply(mk('b01010, 0, 0, 0,      1, 'h0100, 0,       0,       0,      0, 0), "rst3");
        apply(mk('b01010, 1, 0, 0,      0, 0,      'b00010, 0,       0,      0, 1), "rst4");
        apply(mk(0,       0, 1, 'h00C1, 0, 0,      0,       'b00010, 'h00C1, 0, 1), "rst5");
        apply(mk(0,       0, 1, 'h00C2, 0, 0,      0,       0,       0,      1, 1), "rst6");
        pulse_reset("rst_idle");

        // Requesters 0 and 4 (host) held high with immediate acks.
        for (int k = 0; k < 4; k++) begin
            apply(mk('b10001, 0, 0, 0, 1, addr_of(exp_g[k]), 0, 0, 0, 0, k),
                  $sformatf("host%0d.grant", k));
            apply(mk('b10001, 1, (k > 0) ? 1 : 0, 'h00D0 + k, 0, 0, oh(exp_g[k]),
                     (k > 0) ? oh(exp_g[(k > 0) ? k - 1 : 0]) : 0, 'h00D0 + k, 0, k + 1),
                  $sformatf("host%0d.ack", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
